branch_target_unit: RTL and testbench

Registered next-PC target generator in the ID stage. It computes jump, branch and register-indirect targets for the IF-stage PC mux, one cycle after decode. It generalises the fixed J-type address former: PC width, immediate widths and alignment are parameters. It adds PC-relative branches, JR/JALR, a link value and a circular return-address stack (RAS) that predicts JR $31 targets.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_target_unit_if.sv | 36 +++
 rtl/return_addr_stack.sv | 70 +++++++
 rtl/branch_target_unit.sv | 115 +++++++++++
 tb/tb_branch_target_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared mode encodings and sizing helpers for the branch target unit
package branch_pkg;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_J    = 3'd1;
  localparam logic [2:0] MODE_JAL  = 3'd2;
  localparam logic [2:0] MODE_BR   = 3'd3;
  localparam logic [2:0] MODE_JR   = 3'd4;
  localparam logic [2:0] MODE_JALR = 3'd5;

  localparam int RA_REG_DEFAULT = 31;

  // Count must reach RAS_DEPTH itself, hence one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/branch_target_unit_if.sv
// rtl/branch_target_unit_if.sv - decode-side request and IF-side target bundle
interface branch_target_unit_if #(
  parameter int PC_SIZE   = 32,
  parameter int ADDR_SIZE = 26,
  parameter int RAS_DEPTH = 8
);
  import branch_pkg::*;

  localparam int CNT_W = count_width(RAS_DEPTH);

  logic                 i_enable;
  logic                 i_flush;
  logic                 i_valid;
  logic [2:0]           i_mode;
  logic [ADDR_SIZE-1:0] i_imm;
  logic [PC_SIZE-1:0]   i_next_pc;
  logic [4:0]           i_rs_addr;
  logic [PC_SIZE-1:0]   i_rs_data;
  logic [PC_SIZE-1:0]   o_target;
  logic                 o_target_valid;
  logic [PC_SIZE-1:0]   o_link;
  logic [PC_SIZE-1:0]   o_ras_target;
  logic                 o_ras_hit;
  logic [CNT_W-1:0]     o_ras_count;

  modport master (
    output i_enable, i_flush, i_valid, i_mode, i_imm, i_next_pc, i_rs_addr, i_rs_data,
    input  o_target, o_target_valid, o_link, o_ras_target, o_ras_hit, o_ras_count
  );

  modport slave (
    input  i_enable, i_flush, i_valid, i_mode, i_imm, i_next_pc, i_rs_addr, i_rs_data,
    output o_target, o_target_valid, o_link, o_ras_target, o_ras_hit, o_ras_count
  );

endinterface

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack; oldest entry is overwritten when full
module return_addr_stack
  import branch_pkg::*;
#(
  parameter  int PC_SIZE   = 32,
  parameter  int RAS_DEPTH = 8,
  localparam int PTR_W     = $clog2(RAS_DEPTH),
  localparam int CNT_W     = count_width(RAS_DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [PC_SIZE-1:0] i_wdata,
  output logic [PC_SIZE-1:0] o_rdata,
  output logic               o_hit,
  output logic [CNT_W-1:0]   o_count
);

  logic [PC_SIZE-1:0] mem_q [RAS_DEPTH];
  logic [PC_SIZE-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]   tp_q, tp_d, tp_inc;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               nonempty;

  assign nonempty = (count_q != '0);
  assign tp_inc   = tp_q + PTR_W'(1);

  always_comb begin
    mem_d   = mem_q;
    tp_d    = tp_q;
    count_d = count_q;
    // Pop+push on a live stack replaces the top in place: depth is unchanged.
    if (i_pop && i_push && nonempty) begin
      mem_d[tp_q] = i_wdata;
    end else begin
      if (i_pop && nonempty) begin
        tp_d    = tp_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
      if (i_push) begin
        mem_d[tp_inc] = i_wdata;
        tp_d          = tp_inc;
        if (count_q != CNT_W'(RAS_DEPTH)) begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tp_q    <= '0;
      count_q <= '0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
    end
  end

  // Contents are left stale on reset; count alone decides validity.
  always_ff @(posedge i_clock) begin
    mem_q <= mem_d;
  end

  assign o_rdata = mem_q[tp_q];
  assign o_hit   = i_pop && nonempty;
  assign o_count = count_q;

endmodule

// File: rtl/branch_target_unit.sv
// rtl/branch_target_unit.sv - registered jump/branch/indirect target former with RAS prediction
module branch_target_unit
  import branch_pkg::*;
#(
  parameter int PC_SIZE     = 32,
  parameter int ADDR_SIZE   = 26,
  parameter int BR_IMM_SIZE = 16,
  parameter int LOWER_BITS  = 2,
  parameter int RAS_DEPTH   = 8,
  parameter int RA_REG      = RA_REG_DEFAULT
) (
  input logic                  i_clock,
  input logic                  i_reset,
  branch_target_unit_if.slave  bus
);

  localparam int CNT_W = count_width(RAS_DEPTH);

  logic                   mode_ok, is_link, is_indirect;
  logic                   ras_push, ras_pop, ras_hit;
  logic [PC_SIZE-1:0]     ras_rdata;
  logic [CNT_W-1:0]       ras_count;
  logic signed [BR_IMM_SIZE-1:0] br_imm;
  logic [PC_SIZE-1:0]     j_target, br_target, calc_target;

  logic [PC_SIZE-1:0] target_q, target_d;
  logic               target_valid_q, target_valid_d;
  logic [PC_SIZE-1:0] link_q, link_d;
  logic [PC_SIZE-1:0] ras_target_q, ras_target_d;
  logic               ras_hit_q, ras_hit_d;

  assign mode_ok     = bus.i_valid && (bus.i_mode >= MODE_J) && (bus.i_mode <= MODE_JALR);
  assign is_link     = (bus.i_mode == MODE_JAL) || (bus.i_mode == MODE_JALR);
  assign is_indirect = (bus.i_mode == MODE_JR)  || (bus.i_mode == MODE_JALR);

  // RAS only moves on a real, unstalled, unflushed instruction.
  assign ras_push = bus.i_enable && !bus.i_flush && mode_ok && is_link;
  assign ras_pop  = bus.i_enable && !bus.i_flush && mode_ok && is_indirect
                    && (bus.i_rs_addr == 5'(RA_REG));

  assign br_imm    = bus.i_imm[BR_IMM_SIZE-1:0];
  assign j_target  = {bus.i_next_pc[PC_SIZE-1:ADDR_SIZE+LOWER_BITS], bus.i_imm, {LOWER_BITS{1'b0}}};
  assign br_target = bus.i_next_pc + (PC_SIZE'(br_imm) << LOWER_BITS);

  always_comb begin
    calc_target = bus.i_rs_data;
    if ((bus.i_mode == MODE_J) || (bus.i_mode == MODE_JAL)) begin
      calc_target = j_target;
    end else if (bus.i_mode == MODE_BR) begin
      calc_target = br_target;
    end
  end

  return_addr_stack #(
    .PC_SIZE   (PC_SIZE),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (ras_push),
    .i_pop   (ras_pop),
    .i_wdata (bus.i_next_pc),
    .o_rdata (ras_rdata),
    .o_hit   (ras_hit),
    .o_count (ras_count)
  );

  always_comb begin
    target_d       = target_q;
    target_valid_d = target_valid_q;
    link_d         = link_q;
    ras_target_d   = ras_target_q;
    ras_hit_d      = ras_hit_q;
    if (bus.i_flush) begin
      target_valid_d = 1'b0;
      ras_hit_d      = 1'b0;
    end else if (bus.i_enable) begin
      target_valid_d = mode_ok;
      ras_hit_d      = ras_hit;
      if (mode_ok) begin
        target_d = calc_target;
      end
      if (mode_ok && is_link) begin
        link_d = bus.i_next_pc;
      end
      if (ras_hit) begin
        ras_target_d = ras_rdata;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      target_q       <= '0;
      target_valid_q <= 1'b0;
      link_q         <= '0;
      ras_target_q   <= '0;
      ras_hit_q      <= 1'b0;
    end else begin
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      link_q         <= link_d;
      ras_target_q   <= ras_target_d;
      ras_hit_q      <= ras_hit_d;
    end
  end

  assign bus.o_target       = target_q;
  assign bus.o_target_valid = target_valid_q;
  assign bus.o_link         = link_q;
  assign bus.o_ras_target   = ras_target_q;
  assign bus.o_ras_hit      = ras_hit_q;
  assign bus.o_ras_count    = ras_count;

endmodule

// File: tb/tb_branch_target_unit.sv
// tb/tb_branch_target_unit.sv - vector, directed and randomized checks against a queue-based model
module tb_branch_target_unit;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_unit_if bus ();

  branch_target_unit dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_target, m_link, m_rtarget;
  logic        m_valid, m_hit;
  logic [31:0] m_stack [$];

  typedef struct {
    logic [2:0]  md;
    logic [31:0] npc;
    logic [25:0] imm;
    logic [31:0] rsd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic fl, input logic en, input logic vld,
                            input logic [2:0] md, input logic [25:0] imm, input logic [31:0] npc,
                            input logic [4:0] rs, input logic [31:0] rsd);
    logic is_pop, is_push;
    if (r) begin
      m_target = 0; m_link = 0; m_rtarget = 0; m_valid = 0; m_hit = 0;
      m_stack.delete();
    end else if (fl) begin
      m_valid = 0; m_hit = 0;
    end else if (en) begin
      m_valid = 0; m_hit = 0;
      if (vld && md >= 3'd1 && md <= 3'd5) begin
        m_valid = 1;
        case (md)
          3'd1, 3'd2: m_target = (npc & 32'hF000_0000) | ({6'd0, imm} * 4);
          3'd3:       m_target = npc + 32'($signed(imm[15:0])) * 4;
          default:    m_target = rsd;
        endcase
        is_push = (md == 3'd2) || (md == 3'd5);
        is_pop  = ((md == 3'd4) || (md == 3'd5)) && (rs == 5'd31);
        if (is_push) m_link = npc;
        if (is_pop && is_push && m_stack.size() > 0) begin
          m_hit = 1;
          m_rtarget = m_stack[m_stack.size()-1];
          m_stack[m_stack.size()-1] = npc;
        end else begin
          if (is_pop && m_stack.size() > 0) begin
            m_hit = 1;
            m_rtarget = m_stack.pop_back();
          end
          if (is_push) begin
            m_stack.push_back(npc);
            if (m_stack.size() > 8) void'(m_stack.pop_front());
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic fl, input logic en, input logic vld,
                      input logic [2:0] md, input logic [25:0] imm, input logic [31:0] npc,
                      input logic [4:0] rs, input logic [31:0] rsd);
    rst = r; bus.i_flush = fl; bus.i_enable = en; bus.i_valid = vld; bus.i_mode = md;
    bus.i_imm = imm; bus.i_next_pc = npc; bus.i_rs_addr = rs; bus.i_rs_data = rsd;
    @(posedge clk);
    #1;
    model_step(r, fl, en, vld, md, imm, npc, rs, rsd);
    check("target", bus.o_target, m_target);
    check("target_valid", 32'(bus.o_target_valid), 32'(m_valid));
    check("link", bus.o_link, m_link);
    check("ras_target", bus.o_ras_target, m_rtarget);
    check("ras_hit", 32'(bus.o_ras_hit), 32'(m_hit));
    check("ras_count", 32'(bus.o_ras_count), 32'(m_stack.size()));
  endtask

  task automatic op(input logic [2:0] md, input logic [31:0] npc, input logic [25:0] imm,
                    input logic [4:0] rs, input logic [31:0] rsd);
    step(1'b0, 1'b0, 1'b1, 1'b1, md, imm, npc, rs, rsd);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, MODE_NONE, 26'd0, 32'd0, 5'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] saved_link, saved_target;

    vt[0] = '{MODE_J,  32'h4000_1000, 26'h000_0123, 32'h0,         32'h4000_048C};
    vt[1] = '{MODE_BR, 32'h0000_0100, 26'h000_FFFE, 32'h0,         32'h0000_00F8};
    vt[2] = '{MODE_BR, 32'h0000_0100, 26'h000_0004, 32'h0,         32'h0000_0110};
    vt[3] = '{MODE_BR, 32'hFFFF_FFFC, 26'h000_0001, 32'h0,         32'h0000_0000};
    vt[4] = '{MODE_JR, 32'h0000_0040, 26'h0,        32'hDEAD_BEE0, 32'hDEAD_BEE0};

    do_reset();
    do_reset();
    check("reset_target", bus.o_target, 32'h0);
    check("reset_valid", 32'(bus.o_target_valid), 32'h0);
    check("reset_count", 32'(bus.o_ras_count), 32'h0);

    for (int i = 0; i < 5; i++) begin
      op(vt[i].md, vt[i].npc, vt[i].imm, 5'd3, vt[i].rsd);
      check("tbl_target", bus.o_target, vt[i].exp);
      check("tbl_valid", 32'(bus.o_target_valid), 32'h1);
      check("tbl_count", 32'(bus.o_ras_count), 32'h0);
    end

    op(MODE_JAL, 32'h0040_0020, 26'h0, 5'd0, 32'h0);
    check("jal_link", bus.o_link, 32'h0040_0020);
    check("jal_count", 32'(bus.o_ras_count), 32'h1);
    op(MODE_JR, 32'h0000_0800, 26'h0, 5'd31, 32'h1234_5678);
    check("jr_target", bus.o_target, 32'h1234_5678);
    check("jr_ras_target", bus.o_ras_target, 32'h0040_0020);
    check("jr_hit", 32'(bus.o_ras_hit), 32'h1);
    check("jr_count", 32'(bus.o_ras_count), 32'h0);
    op(MODE_JR, 32'h0000_0800, 26'h0, 5'd31, 32'h1234_5678);
    check("jr_empty_hit", 32'(bus.o_ras_hit), 32'h0);

    do_reset();
    for (int k = 1; k <= 9; k++) op(MODE_JAL, 32'(k * 'h100), 26'h0, 5'd0, 32'h0);
    check("ovf_count", 32'(bus.o_ras_count), 32'd8);
    for (int k = 9; k >= 2; k--) begin
      op(MODE_JR, 32'h0, 26'h0, 5'd31, 32'h0);
      check("ovf_pop_target", bus.o_ras_target, 32'(k * 'h100));
      check("ovf_pop_hit", 32'(bus.o_ras_hit), 32'h1);
    end
    op(MODE_JR, 32'h0, 26'h0, 5'd31, 32'h0);
    check("ovf_last_hit", 32'(bus.o_ras_hit), 32'h0);

    do_reset();
    op(MODE_JAL, 32'h200, 26'h0, 5'd0, 32'h0);
    op(MODE_JAL, 32'h300, 26'h0, 5'd0, 32'h0);
    op(MODE_JALR, 32'h500, 26'h0, 5'd31, 32'h0000_0ABC);
    check("jalr_hit", 32'(bus.o_ras_hit), 32'h1);
    check("jalr_ras_target", bus.o_ras_target, 32'h300);
    check("jalr_count", 32'(bus.o_ras_count), 32'd2);
    op(MODE_JR, 32'h0, 26'h0, 5'd31, 32'h0);
    check("jalr_next_pop", bus.o_ras_target, 32'h500);

    saved_link   = bus.o_link;
    saved_target = bus.o_target;
    step(1'b0, 1'b0, 1'b0, 1'b1, MODE_JAL, 26'h1, 32'h700, 5'd0, 32'h0);
    check("stall_link", bus.o_link, saved_link);
    check("stall_target", bus.o_target, saved_target);
    check("stall_count", 32'(bus.o_ras_count), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, MODE_JAL, 26'h1, 32'h700, 5'd0, 32'h0);
    check("flush_valid", 32'(bus.o_target_valid), 32'h0);
    check("flush_count", 32'(bus.o_ras_count), 32'd1);
    check("flush_link", bus.o_link, saved_link);

    do_reset();
    for (int k = 1; k <= 5; k++) op(MODE_JAL, 32'(k * 'h40), 26'h0, 5'd0, 32'h0);
    check("pre_reset_count", 32'(bus.o_ras_count), 32'd5);
    step(1'b1, 1'b0, 1'b1, 1'b1, MODE_JAL, 26'h1, 32'h900, 5'd0, 32'h0);
    check("mid_reset_link", bus.o_link, 32'h0);
    check("mid_reset_count", 32'(bus.o_ras_count), 32'h0);
    op(MODE_JR, 32'h0, 26'h0, 5'd31, 32'h0);
    check("post_reset_hit", 32'(bus.o_ras_hit), 32'h0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 90), 3'($urandom_range(0, 7)), 26'($urandom),
           ($urandom_range(0, 1) == 1) ? 32'($urandom) & 32'hFFFF_FFFC : 32'hFFFF_FFF0,
           ($urandom_range(0, 1) == 1) ? 5'd31 : 5'($urandom), 32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
